prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that writes the CPU's instruction memory. It receives a framed byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words. Each word is written through the instruction-memory write port, and the CPU core is held in reset until a complete, checksum-clean frame has been loaded. It sits between the host byte link and the instruction RAM, and produces the words that the instruction decoder later consumes.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `AUTO_RUN`, default 1: 1 releases `cpu_hold` after a good frame; 0 keeps the hold until `run_req`.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` valid.
- `rx_ready`  out  1: loader accepts a byte; transfer occurs when `rx_valid & rx_ready` at a rising edge.
- `run_req`  in  1: release hold (used when `AUTO_RUN`=0).
- `mem_addr`  out  16: instruction-memory write address.
- `mem_wrdata`  out  16: instruction word.
- `mem_wen`  out  1: one-cycle write strobe.
- `cpu_hold`  out  1: core held in reset while high.
- `done`  out  1: one-cycle pulse, frame loaded OK.
- `err`  out  1: sticky checksum error.
- `word_cnt`  out  16: words written in the current frame.

## Operation
- Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN words as (hi, lo), then CSUM.
- LEN counts 16-bit words.
- CSUM: the 8-bit sum of every byte after SYNC, including CSUM itself, must be 8'h00.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, RUN.
- IDLE: a byte other than `SYNC_BYTE` is consumed and discarded. SYNC goes to ADDR_H, clears `err`, sets `cpu_hold`, and zeroes `word_cnt` and the checksum.
- ADDR_H/ADDR_L latch the start address.
- LEN_H/LEN_L latch the length. On LEN_L, LEN=0 goes straight to CSUM; otherwise to DATA_H.
- DATA_H latches the high byte.
- DATA_L forms the word, schedules the write, and increments the address and `word_cnt`. When `word_cnt` reaches LEN, go to CSUM; else go back to DATA_H.
- Address arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000, with no error.
- CSUM, sum == 0: pulse `done`. With `AUTO_RUN`=1 go to RUN and drop `cpu_hold`; otherwise stay in CSUM-wait until `run_req`, then RUN.
- CSUM, sum != 0: set `err`, keep `cpu_hold`=1, return to IDLE. Words already written are not rolled back.
- RUN: bytes are still accepted. SYNC re-enters ADDR_H and reasserts `cpu_hold` (reload); other bytes are dropped.
- `run_req` outside the CSUM-wait state is ignored.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `mem_wen`=0, `mem_addr`=0, `mem_wrdata`=0, `cpu_hold`=1, `done`=0, `err`=0, `word_cnt`=0.
- `rx_ready` rises on the first cycle after `reset` deasserts and stays high in every state. The loader sustains one byte per cycle.
- Write latency: the word is on `mem_addr`/`mem_wrdata` with `mem_wen`=1 for exactly one cycle, on the cycle after the DATA_L transfer. Outputs are registered.
- `mem_addr`/`mem_wrdata` hold their last values when `mem_wen`=0.
- `done` pulses on the cycle after the CSUM transfer.
- `cpu_hold` falls on the same cycle as `done` when `AUTO_RUN`=1, or on the cycle after `run_req` is sampled.
- `rx_valid` low stalls the FSM indefinitely. There is no timeout.
- `reset` mid-frame: all state returns to reset values on the next edge, and the partial frame is discarded.
- `reset` on the same cycle as a DATA_L transfer: reset wins, and no write is issued.

## Configuration
- `PROG_LOADER_CSUM_EN` defined: CSUM byte expected, checked as above, and `err` functional.
- Not defined: no CSUM byte in the frame. The last DATA_L (or LEN_L with LEN=0) completes the frame, `done` pulses the following cycle, and `err` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the loader state enum;
  - `SYNC_BYTE` default constant;
  - 16-bit word/address width constants.
- One sub-module, `loader_csum`: 8-bit accumulator with clear, add-on-accept, and zero-flag. It is instantiated only under `PROG_LOADER_CSUM_EN`.

## Test plan
- Frame A5,01,00,00,02,12,34,AB,CD, CSUM=8'h??(computed) -> writes 16'h1234@16'h0100 and 16'hABCD@16'h0101, one `mem_wen` cycle each; `done` 1 cycle; `cpu_hold` falls; `word_cnt`=2.
- Same frame with CSUM+1 -> both writes occur; `err`=1; `cpu_hold` stays 1; no `done`; next SYNC clears `err`.
- Start address 16'hFFFF, LEN=2 -> writes to 16'hFFFF then 16'h0000.
- LEN=0 with valid CSUM -> no `mem_wen`; `done` pulses; hold released.
- `reset` asserted between DATA_H and DATA_L -> no write; all outputs return to reset values; a subsequent full frame loads correctly.
- `AUTO_RUN`=0 with a good frame -> `done` pulses and `cpu_hold` stays 1 until `run_req`, then falls the next cycle. An SYNC arriving in RUN reasserts `cpu_hold`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM state encoding, default sync marker
// and instruction word/address widths.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_CSUM,
    ST_RUN_WAIT,
    ST_RUN
  } loader_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port of the loader.
interface prog_loader_if;
  import cpu_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wrdata;
  logic              mem_wen;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_wrdata, mem_wen
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr, mem_wrdata, mem_wen
  );

endinterface

// File: rtl/prog_loader_csum.sv
// 8-bit running checksum for the loader frame; zero reports whether the sum
// including the byte currently presented on data would be 8'h00.
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] data,
  output logic       zero
);

  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (reset || clr) sum <= 8'h00;
    else if (add)     sum <= 8'(sum + data);
  end

  // Looking through to the presented byte lets the check byte be judged on its own transfer.
  assign zero = (8'(sum + data) == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> 16-bit instruction writes, CPU held until load OK.
// Optional checksum byte and sticky err enabled by defining PROG_LOADER_CSUM_EN.
//
// state       | meaning
// ST_IDLE     | hunting for SYNC, other bytes dropped
// ST_ADDR_H/L | latching start address
// ST_LEN_H/L  | latching word count
// ST_DATA_H/L | collecting hi/lo byte of a word, write on lo
// ST_CSUM     | waiting for checksum byte
// ST_RUN_WAIT | frame good, hold kept until run_req
// ST_RUN      | core released, SYNC starts a reload
module prog_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter bit         AUTO_RUN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  input  logic              run_req,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_cnt
);

  loader_state_e state, state_next;

  logic              accept;
  logic              is_sync;
  logic              len_zero;
  logic              last_word;
  logic              sync_hit;
  logic              wr_fire;
  logic              frame_ok;
  logic              release_run;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] len;
  logic [7:0]        data_hi;

  assign accept    = bus.rx_valid & bus.rx_ready;
  assign is_sync   = (bus.rx_data == SYNC_BYTE);
  assign len_zero  = ({len[15:8], bus.rx_data} == 16'h0000);
  assign last_word = (16'(word_cnt + 16'd1) == len);

`ifdef PROG_LOADER_CSUM_EN
  logic csum_zero;
  logic csum_add;
  logic frame_bad;

  assign csum_add = accept && (state != ST_IDLE) && (state != ST_RUN) && (state != ST_RUN_WAIT);

  loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (sync_hit),
    .add   (csum_add),
    .data  (bus.rx_data),
    .zero  (csum_zero)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    sync_hit    = 1'b0;
    wr_fire     = 1'b0;
    frame_ok    = 1'b0;
    release_run = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    frame_bad   = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_RUN: begin
        if (accept && is_sync) begin
          state_next = ST_ADDR_H;
          sync_hit   = 1'b1;
        end
      end
      ST_ADDR_H: if (accept) state_next = ST_ADDR_L;
      ST_ADDR_L: if (accept) state_next = ST_LEN_H;
      ST_LEN_H:  if (accept) state_next = ST_LEN_L;
      ST_LEN_L: begin
        if (accept) begin
          if (len_zero) begin
`ifdef PROG_LOADER_CSUM_EN
            state_next = ST_CSUM;
`else
            frame_ok = 1'b1;
`endif
          end else begin
            state_next = ST_DATA_H;
          end
        end
      end
      ST_DATA_H: if (accept) state_next = ST_DATA_L;
      ST_DATA_L: begin
        if (accept) begin
          wr_fire = 1'b1;
          if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
            state_next = ST_CSUM;
`else
            frame_ok = 1'b1;
`endif
          end else begin
            state_next = ST_DATA_H;
          end
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (csum_zero) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
`endif
      ST_RUN_WAIT: begin
        if (run_req) begin
          state_next  = ST_RUN;
          release_run = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (frame_ok) state_next = AUTO_RUN ? ST_RUN : ST_RUN_WAIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rx_ready   <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wrdata <= '0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      word_cnt       <= '0;
      addr           <= '0;
      len            <= '0;
      data_hi        <= 8'h00;
    end else begin
      bus.rx_ready <= 1'b1;
      bus.mem_wen  <= 1'b0;
      done         <= 1'b0;
      if (sync_hit) begin
        word_cnt <= '0;
        cpu_hold <= 1'b1;
      end
      if (accept) begin
        case (state)
          ST_ADDR_H: addr[15:8] <= bus.rx_data;
          ST_ADDR_L: addr[7:0]  <= bus.rx_data;
          ST_LEN_H:  len[15:8]  <= bus.rx_data;
          ST_LEN_L:  len[7:0]   <= bus.rx_data;
          ST_DATA_H: data_hi    <= bus.rx_data;
          default: ;
        endcase
      end
      // Address wraps modulo 2^16 by construction.
      if (wr_fire) begin
        bus.mem_addr   <= addr;
        bus.mem_wrdata <= {data_hi, bus.rx_data};
        bus.mem_wen    <= 1'b1;
        addr           <= 16'(addr + 16'd1);
        word_cnt       <= 16'(word_cnt + 16'd1);
      end
      if (frame_ok) begin
        done <= 1'b1;
        if (AUTO_RUN) cpu_hold <= 1'b0;
      end
      if (release_run) cpu_hold <= 1'b0;
    end
  end

`ifdef PROG_LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset)          err <= 1'b0;
    else if (sync_hit)  err <= 1'b0;
    else if (frame_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized frames checked against a frame-level model
// (expected writes, done timing, hold/err state) for AUTO_RUN=1 and AUTO_RUN=0 instances.
module tb_prog_loader;
  import cpu_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_req_a = 1'b0;
  logic        run_req_b = 1'b0;
  logic        cpu_hold_a, done_a, err_a;
  logic        cpu_hold_b, done_b, err_b;
  logic [15:0] word_cnt_a, word_cnt_b;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  fb[$];
  int          lo_idx[$];
  logic [15:0] fw[$];
  int          xc[$];
  wr_t         wr_q[$];
  int          done_q[$];
  logic [7:0]  fsum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader_if bus_a ();
  prog_loader_if bus_b ();

  prog_loader #(.SYNC_BYTE(8'hA5), .AUTO_RUN(1'b1)) u_auto (
    .clk(clk), .reset(reset), .bus(bus_a), .run_req(run_req_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a), .word_cnt(word_cnt_a)
  );

  prog_loader #(.SYNC_BYTE(8'hA5), .AUTO_RUN(1'b0)) u_man (
    .clk(clk), .reset(reset), .bus(bus_b), .run_req(run_req_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b), .word_cnt(word_cnt_b)
  );

  always @(negedge clk) begin
    wr_t w;
    if (bus_a.mem_wen === 1'b1) begin
      w.addr = bus_a.mem_addr;
      w.data = bus_a.mem_wrdata;
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
    if (done_a === 1'b1) done_q.push_back(cyc);
  end

  task automatic put(input logic [7:0] b);
    fb.push_back(b);
    fsum = 8'(fsum + b);
  endtask

  // Frame = [junk] SYNC ADDR LEN words [CSUM]; bad is added to a correct checksum.
  task automatic build_frame(input logic [15:0] a, input int junk, input logic [7:0] bad);
    logic [7:0]  b;
    logic [15:0] n;
    fb.delete();
    lo_idx.delete();
    for (int i = 0; i < junk; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h3C;
      fb.push_back(b);
    end
    fb.push_back(8'hA5);
    fsum = 8'h00;
    n = 16'(fw.size());
    put(a[15:8]);
    put(a[7:0]);
    put(n[15:8]);
    put(n[7:0]);
    foreach (fw[i]) begin
      put(fw[i][15:8]);
      put(fw[i][7:0]);
      lo_idx.push_back(fb.size() - 1);
    end
`ifdef PROG_LOADER_CSUM_EN
    fb.push_back(8'(8'h00 - fsum + bad));
`else
    if (bad != 8'h00) fsum = 8'h00;
`endif
  endtask

  task automatic send(input bit man, input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      if (man) begin
        bus_b.rx_data  = fb[i];
        bus_b.rx_valid = 1'b1;
      end else begin
        bus_a.rx_data  = fb[i];
        bus_a.rx_valid = 1'b1;
      end
      @(posedge clk); #1;
      xc.push_back(cyc);
      bus_a.rx_valid = 1'b0;
      bus_b.rx_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [52:0] got;
    logic [52:0] exp;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    exp = {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    got = {bus_a.rx_ready, bus_a.mem_wen, bus_a.mem_addr, bus_a.mem_wrdata,
           cpu_hold_a, done_a, err_a, word_cnt_a};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_a: got %h want %h", got, exp);
    end
    got = {bus_b.rx_ready, bus_b.mem_wen, bus_b.mem_addr, bus_b.mem_wrdata,
           cpu_hold_b, done_b, err_b, word_cnt_b};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_b: got %h want %h", got, exp);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus_a.rx_ready, bus_b.rx_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL rx_ready_rise: got %b want 11", {bus_a.rx_ready, bus_b.rx_ready});
    end
  endtask

  // Load fw at address a on the AUTO_RUN=1 instance and check it against the frame-level model.
  task automatic test_load(input string tag, input logic [15:0] a, input int junk,
                           input logic [7:0] bad, input int gap);
    int          n;
    int          last;
    bit          good;
    logic [15:0] exp_a;
    n = fw.size();
    good = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
    good = (bad == 8'h00);
`endif
    build_frame(a, junk, bad);
    last = fb.size() - 1;
    wr_q.delete();
    done_q.delete();
    xc.delete();
    send(1'b0, 0, junk, gap);
    vectors++;
    if ({cpu_hold_a, err_a, word_cnt_a} !== {1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL %s sync: hold/err/cnt got %b/%b/%h want 1/0/0000", tag, cpu_hold_a, err_a, word_cnt_a);
    end
    send(1'b0, junk + 1, last, gap);
    @(negedge clk); #1;
    vectors++;
    if (wr_q.size() != n) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d want %0d", tag, wr_q.size(), n);
    end
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      exp_a = 16'(a + 16'(i));
      vectors++;
      if (wr_q[i].addr !== exp_a || wr_q[i].data !== fw[i] || wr_q[i].cyc != xc[lo_idx[i]]) begin
        miscompares++;
        $display("FAIL %s write%0d: got %h@%h cyc %0d want %h@%h cyc %0d", tag, i,
                 wr_q[i].data, wr_q[i].addr, wr_q[i].cyc, fw[i], exp_a, xc[lo_idx[i]]);
      end
    end
    vectors++;
    if (done_q.size() != (good ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d want %0d", tag, done_q.size(), good ? 1 : 0);
    end else if (good) begin
      vectors++;
      if (done_q[0] != xc[last]) begin
        miscompares++;
        $display("FAIL %s done_cycle: got %0d want %0d", tag, done_q[0], xc[last]);
      end
    end
    vectors++;
    if ({cpu_hold_a, err_a, word_cnt_a} !== {!good, !good, 16'(n)}) begin
      miscompares++;
      $display("FAIL %s end_state: hold/err/cnt got %b/%b/%h want %b/%b/%h", tag,
               cpu_hold_a, err_a, word_cnt_a, !good, !good, 16'(n));
    end
    @(posedge clk); #1;
    vectors++;
    if (done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_width: got %b want 0", tag, done_a);
    end
  endtask

  task automatic test_basic;
    fw = '{16'h1234, 16'hABCD};
    test_load("basic", 16'h0100, 0, 8'h00, 0);
  endtask

  task automatic test_wrap;
    fw = '{16'hDEAD, 16'h0BAD};
    test_load("wrap", 16'hFFFF, 1, 8'h00, 0);
  endtask

  task automatic test_csum_err;
    fw = '{16'h1234, 16'hABCD};
    test_load("csum_bad", 16'h0100, 0, 8'h01, 0);
    fw = '{16'h5A5A};
    test_load("csum_recover", 16'h0300, 2, 8'h00, 1);
  endtask

  task automatic test_len0;
    fw.delete();
    test_load("len0", 16'h0050, 1, 8'h00, 0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 8; f++) begin
      logic [7:0] bad;
      fw.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) fw.push_back(16'($urandom));
      bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      test_load("random", 16'($urandom), int'($urandom_range(0, 3)), bad, 2);
    end
  endtask

  task automatic test_reset_mid;
    logic [52:0] got;
    fw = '{16'hCAFE, 16'hBEEF};
    build_frame(16'h0200, 0, 8'h00);
    wr_q.delete();
    xc.delete();
    send(1'b0, 0, lo_idx[0] - 1, 0);
    bus_a.rx_data  = fb[lo_idx[0]];
    bus_a.rx_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus_a.rx_valid = 1'b0;
    got = {bus_a.rx_ready, bus_a.mem_wen, bus_a.mem_addr, bus_a.mem_wrdata,
           cpu_hold_a, done_a, err_a, word_cnt_a};
    vectors++;
    if (got !== {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h want %h", got,
               {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000});
    end
    @(negedge clk); #1;
    vectors++;
    if (wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_nowrite: got %0d writes want 0", wr_q.size());
    end
    reset = 1'b0;
    @(posedge clk); #1;
    fw = '{16'h7001, 16'h7002, 16'h7003};
    test_load("after_reset", 16'h0400, 0, 8'h00, 1);
  endtask

  task automatic test_manual_run;
    fw = '{16'h0F0F, 16'h1111, 16'h2222};
    build_frame(16'h0010, 0, 8'h00);
    run_req_b = 1'b1;
    @(posedge clk); #1;
    run_req_b = 1'b0;
    vectors++;
    if (cpu_hold_b !== 1'b1) begin
      miscompares++;
      $display("FAIL man_stray_run: hold got %b want 1", cpu_hold_b);
    end
    xc.delete();
    send(1'b1, 0, fb.size() - 1, 1);
    vectors++;
    if ({done_b, cpu_hold_b, word_cnt_b} !== {1'b1, 1'b1, 16'd3}) begin
      miscompares++;
      $display("FAIL man_done: done/hold/cnt got %b/%b/%h want 1/1/0003", done_b, cpu_hold_b, word_cnt_b);
    end
    repeat ($urandom_range(2, 6)) begin @(posedge clk); #1; end
    vectors++;
    if (cpu_hold_b !== 1'b1) begin
      miscompares++;
      $display("FAIL man_hold_wait: hold got %b want 1", cpu_hold_b);
    end
    run_req_b = 1'b1;
    @(posedge clk); #1;
    run_req_b = 1'b0;
    vectors++;
    if (cpu_hold_b !== 1'b0) begin
      miscompares++;
      $display("FAIL man_release: hold got %b want 0", cpu_hold_b);
    end
    send(1'b1, 0, 0, 0);
    vectors++;
    if (cpu_hold_b !== 1'b1) begin
      miscompares++;
      $display("FAIL man_reload_hold: hold got %b want 1", cpu_hold_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.rx_data  = 8'h00;
    bus_a.rx_valid = 1'b0;
    bus_b.rx_data  = 8'h00;
    bus_b.rx_valid = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
`ifdef PROG_LOADER_CSUM_EN
    test_csum_err();
`endif
    test_len0();
    test_random();
    test_reset_mid();
    test_manual_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
